// File: rtl/inst_mem_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory controller.
// FSM encoding and reset-time parameter defaults.
package inst_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DATA_W_DFLT  = 32;
    localparam int ADDR_W_DFLT  = 32;
    localparam int DEPTH_W_DFLT = 8;

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Bundles the boot-load, fetch and RAM ports of the instruction-memory controller.
// slave = controller side, master = surrounding system (boot source, IF stage, RAM).
interface inst_mem_ctrl_if
    import inst_mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int DEPTH_W = DEPTH_W_DFLT
);
    logic               boot_start;
    logic [DEPTH_W:0]   ld_len;
    logic               ld_valid;
    logic [DATA_W-1:0]  ld_data;
    logic               ld_ready;
    logic               ld_done;
    logic               cpu_hold;
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_valid;
    logic [DATA_W-1:0]  if_inst;
    logic               if_err;
    logic               mem_en;
    logic               mem_we;
    logic [DEPTH_W-1:0] mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  boot_start, ld_len, ld_valid, ld_data, if_req, if_addr, mem_rdata,
        output ld_ready, ld_done, cpu_hold, if_valid, if_inst, if_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output boot_start, ld_len, ld_valid, ld_data, if_req, if_addr, mem_rdata,
        input  ld_ready, ld_done, cpu_hold, if_valid, if_inst, if_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Instruction-memory sequencer: boot-loads a program into a 1-cycle sync RAM,
// then serves IF-stage fetches with range/alignment checking.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int DEPTH_W = DEPTH_W_DFLT
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_mem_ctrl_if.slave bus
);

    localparam logic [DEPTH_W:0] LEN_ONE = (DEPTH_W + 1)'(1);
    localparam logic [DEPTH_W:0] LEN_MAX = {1'b1, {DEPTH_W{1'b0}}};

    state_t           state, state_nxt;
    logic [DEPTH_W:0] cnt, cnt_nxt;
    logic [DEPTH_W:0] len, len_nxt;
    logic [DEPTH_W:0] len_sat;
    logic             fetch_vld, fetch_vld_nxt;
    logic             fetch_err, fetch_err_nxt;
    logic             addr_ok;

    // Any ld_len with the top bit set is at least 2**DEPTH_W words.
    assign len_sat = bus.ld_len[DEPTH_W] ? LEN_MAX : bus.ld_len;
    assign addr_ok = (bus.if_addr[1:0] == 2'b00) &&
                     ((bus.if_addr >> (DEPTH_W + 2)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len       <= '0;
            fetch_vld <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            fetch_vld <= fetch_vld_nxt;
            fetch_err <= fetch_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        len_nxt       = len;
        fetch_vld_nxt = 1'b0;
        fetch_err_nxt = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.ld_done   = 1'b0;
        bus.cpu_hold  = 1'b1;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        unique case (state)
            ST_IDLE: begin
                if (bus.boot_start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                    len_nxt   = len_sat;
                end
            end
            ST_LOAD: begin
                if (len == '0) begin
                    bus.ld_done = 1'b1;
                    state_nxt   = ST_RUN;
                end else begin
                    bus.ld_ready = 1'b1;
                    if (bus.ld_valid) begin
                        bus.mem_en    = 1'b1;
                        bus.mem_we    = 1'b1;
                        bus.mem_addr  = cnt[DEPTH_W-1:0];
                        bus.mem_wdata = bus.ld_data;
                        cnt_nxt       = cnt + LEN_ONE;
                        if (cnt == len - LEN_ONE) begin
                            bus.ld_done = 1'b1;
                            state_nxt   = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                bus.cpu_hold = 1'b0;
                // A reboot request pre-empts a fetch presented in the same cycle.
                if (bus.boot_start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                    len_nxt   = len_sat;
                end else if (bus.if_req) begin
                    fetch_vld_nxt = 1'b1;
                    if (addr_ok) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.if_addr[DEPTH_W+1:2];
                    end else begin
                        fetch_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.if_valid = fetch_vld;
    assign bus.if_err   = fetch_vld & fetch_err;
    assign bus.if_inst  = (fetch_vld && !fetch_err) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Directed self-checking bench for inst_mem_ctrl with a 1-cycle sync RAM model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_inst_mem_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int DPW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    inst_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_W(DPW)) bus ();

    inst_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_W(DPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 1-cycle synchronous RAM
    logic [DW-1:0] ram [0:(1<<DPW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // {ld_ready, ld_done, cpu_hold, if_valid, if_err, mem_en, mem_we}
    logic [6:0] flags;
    assign flags = {bus.ld_ready, bus.ld_done, bus.cpu_hold, bus.if_valid,
                    bus.if_err, bus.mem_en, bus.mem_we};

    logic [DW-1:0] words [0:3];
    logic [DW-1:0] alt   [0:3];
    logic [DW-1:0] mid   [0:1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.boot_start = 1'b0; bus.ld_len = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
        bus.if_req = 1'b1; bus.if_addr = '0;
        @(negedge clk); #1;
        checks++;
        if (flags !== 7'b0010000) begin
            errors++; $display("FAIL reset_flags got=%b exp=%b", flags, 7'b0010000);
        end
        checks++;
        if (bus.if_inst !== '0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            errors++; $display("FAIL reset_buses inst=%h addr=%h wdata=%h exp=0",
                               bus.if_inst, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (flags !== 7'b0010000) begin
            errors++; $display("FAIL idle_ignores_req got=%b exp=%b", flags, 7'b0010000);
        end
        bus.if_req = 1'b0;
    endtask

    task automatic test_load();
        logic [6:0] exp;
        @(negedge clk); bus.boot_start = 1'b1; bus.ld_len = 9'd4; #1;
        checks++;
        if (flags !== 7'b0010000) begin
            errors++; $display("FAIL load_enter got=%b exp=%b", flags, 7'b0010000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); bus.boot_start = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = words[i]; #1;
            exp = {1'b1, (i == 3), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            checks++;
            if (flags !== exp || bus.mem_addr !== 8'(i) || bus.mem_wdata !== words[i]) begin
                errors++; $display("FAIL load_word%0d flags=%b/%b addr=%h/%h wdata=%h/%h", i,
                                   flags, exp, bus.mem_addr, 8'(i), bus.mem_wdata, words[i]);
            end
        end
        @(negedge clk); bus.ld_valid = 1'b0; #1;
        checks++;
        if (flags !== 7'b0000000) begin
            errors++; $display("FAIL load_to_run got=%b exp=%b", flags, 7'b0000000);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[i] !== words[i]) begin
                errors++; $display("FAIL load_ram%0d got=%h exp=%h", i, ram[i], words[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); bus.if_req = (i < 4); bus.if_addr = 32'(4 * i); #1;
            exp = {1'b0, 1'b0, 1'b0, (i > 0), 1'b0, (i < 4), 1'b0};
            checks++;
            if (flags !== exp) begin
                errors++; $display("FAIL fetch%0d_flags got=%b exp=%b", i, flags, exp);
            end
            if (i < 4) begin
                checks++;
                if (bus.mem_addr !== 8'(i)) begin
                    errors++; $display("FAIL fetch%0d_addr got=%h exp=%h", i, bus.mem_addr, 8'(i));
                end
            end
            if (i > 0) begin
                checks++;
                if (bus.if_inst !== words[i-1]) begin
                    errors++; $display("FAIL fetch%0d_inst got=%h exp=%h", i, bus.if_inst, words[i-1]);
                end
            end
        end
        @(negedge clk); bus.if_req = 1'b0; #1;
        checks++;
        if (flags !== 7'b0000000 || bus.if_inst !== '0) begin
            errors++; $display("FAIL fetch_idle flags=%b inst=%h exp=0", flags, bus.if_inst);
        end
    endtask

    task automatic test_illegal_addr();
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h6; #1;
        checks++;
        if (flags !== 7'b0000000) begin
            errors++; $display("FAIL misalign_noaccess got=%b exp=%b", flags, 7'b0000000);
        end
        @(negedge clk); bus.if_addr = 32'h400; #1;
        checks++;
        if (flags !== 7'b0001100 || bus.if_inst !== '0) begin
            errors++; $display("FAIL misalign_resp flags=%b/%b inst=%h/0", flags, 7'b0001100, bus.if_inst);
        end
        @(negedge clk); bus.if_req = 1'b0; #1;
        checks++;
        if (flags !== 7'b0001100 || bus.if_inst !== '0) begin
            errors++; $display("FAIL range_resp flags=%b/%b inst=%h/0", flags, 7'b0001100, bus.if_inst);
        end
    endtask

    task automatic test_boot_collision();
        logic [6:0] exp;
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h4; #1;
        checks++;
        if (flags !== 7'b0000010 || bus.mem_addr !== 8'd1) begin
            errors++; $display("FAIL pre_boot_fetch flags=%b/%b addr=%h/01", flags, 7'b0000010, bus.mem_addr);
        end
        @(negedge clk); bus.if_addr = 32'h8; bus.boot_start = 1'b1; bus.ld_len = 9'd4; #1;
        checks++;
        if (flags !== 7'b0001000 || bus.if_inst !== words[1]) begin
            errors++; $display("FAIL boot_wins flags=%b/%b inst=%h/%h", flags, 7'b0001000, bus.if_inst, words[1]);
        end
        // boot_start and ld_len changes while loading must be ignored
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.boot_start = (i == 2); bus.ld_len = 9'd1;
            bus.ld_valid = (i % 2 == 0); bus.ld_data = alt[i/2]; #1;
            exp = {1'b1, (i == 6), 1'b1, 1'b0, 1'b0, (i % 2 == 0), (i % 2 == 0)};
            checks++;
            if (flags !== exp) begin
                errors++; $display("FAIL toggle%0d_flags got=%b exp=%b", i, flags, exp);
            end
            if (i % 2 == 0) begin
                checks++;
                if (bus.mem_addr !== 8'(i/2) || bus.mem_wdata !== alt[i/2]) begin
                    errors++; $display("FAIL toggle%0d_write addr=%h/%h wdata=%h/%h", i,
                                       bus.mem_addr, 8'(i/2), bus.mem_wdata, alt[i/2]);
                end
            end
        end
        @(negedge clk); bus.boot_start = 1'b0; bus.ld_valid = 1'b0; bus.if_req = 1'b0; #1;
        checks++;
        if (flags !== 7'b0000000) begin
            errors++; $display("FAIL reload_done got=%b exp=%b", flags, 7'b0000000);
        end
        @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h4;
        @(negedge clk); bus.if_req = 1'b0; #1;
        checks++;
        if (flags !== 7'b0001000 || bus.if_inst !== alt[1]) begin
            errors++; $display("FAIL reload_fetch flags=%b/%b inst=%h/%h", flags, 7'b0001000, bus.if_inst, alt[1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram[i] !== alt[i]) begin
                errors++; $display("FAIL reload_ram%0d got=%h exp=%h", i, ram[i], alt[i]);
            end
        end
    endtask

    task automatic test_reset_midload();
        @(negedge clk); bus.boot_start = 1'b1; bus.ld_len = 9'd4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.boot_start = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = mid[i]; #1;
            checks++;
            if (flags !== 7'b1010011 || bus.mem_addr !== 8'(i)) begin
                errors++; $display("FAIL midload%0d flags=%b/%b addr=%h/%h", i, flags, 7'b1010011, bus.mem_addr, 8'(i));
            end
        end
        @(negedge clk); bus.ld_data = 32'hBBBB_0003; rst_n = 1'b0; #1;
        checks++;
        if (flags !== 7'b0010000 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.if_inst !== '0) begin
            errors++; $display("FAIL async_reset flags=%b/%b addr=%h wdata=%h inst=%h exp=0",
                               flags, 7'b0010000, bus.mem_addr, bus.mem_wdata, bus.if_inst);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (flags !== 7'b0010000) begin
            errors++; $display("FAIL post_reset_idle got=%b exp=%b", flags, 7'b0010000);
        end
        bus.ld_valid = 1'b0;
        checks++;
        if (ram[0] !== mid[0] || ram[1] !== mid[1] || ram[2] !== alt[2]) begin
            errors++; $display("FAIL ram_kept got=%h,%h,%h exp=%h,%h,%h",
                               ram[0], ram[1], ram[2], mid[0], mid[1], alt[2]);
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk); bus.boot_start = 1'b1; bus.ld_len = 9'd0; bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD_BEEF; #1;
        checks++;
        if (flags !== 7'b0010000) begin
            errors++; $display("FAIL zero_enter got=%b exp=%b", flags, 7'b0010000);
        end
        @(negedge clk); bus.boot_start = 1'b0; #1;
        checks++;
        if (flags !== 7'b0110000) begin
            errors++; $display("FAIL zero_done got=%b exp=%b", flags, 7'b0110000);
        end
        @(negedge clk); #1;
        checks++;
        if (flags !== 7'b0000000) begin
            errors++; $display("FAIL zero_run got=%b exp=%b", flags, 7'b0000000);
        end
        bus.ld_valid = 1'b0;
        checks++;
        if (ram[0] !== mid[0]) begin
            errors++; $display("FAIL zero_nowrite got=%h exp=%h", ram[0], mid[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        alt[0] = 32'hA1; alt[1] = 32'hA2; alt[2] = 32'hA3; alt[3] = 32'hA4;
        mid[0] = 32'hB1; mid[1] = 32'hB2;
        test_reset();
        test_load();
        test_back_to_back();
        test_illegal_addr();
        test_boot_collision();
        test_reset_midload();
        test_zero_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
